// File: rtl/stepper_phase_monitor.sv
// Decodes a one-hot stepper coil-phase bus into step pulses, direction, wrapped position and revolution count.
// Define STEPPER_PHASE_MON_SYNC_EN to add a 2-flop synchroniser when the driver runs on an unrelated clock.
module stepper_phase_monitor #(
  parameter int STEPS_PER_REV = 2048,
  parameter int POS_W         = 12,
  parameter int REV_W         = 8,
  parameter int IDLE_CYCLES   = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       signal,
  input  logic             clr,
  output logic             step_pulse,
  output logic             step_dir,
  output logic [POS_W-1:0] position,
  output logic [REV_W-1:0] revs,
  output logic             moving,
  output logic             err
);

  localparam int               CNT_W     = $clog2(IDLE_CYCLES + 1);
  localparam logic [POS_W-1:0] POS_MAX   = POS_W'(STEPS_PER_REV - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES);

  logic [3:0]       s_q;
  logic             have_phase;
  logic [1:0]       last_phase;
  logic [CNT_W-1:0] idle_cnt;

  logic             code_idle;
  logic             code_legal;
  logic [1:0]       new_phase;
  logic [1:0]       delta;
  logic             step_fwd;
  logic             step_rev;
  logic             err_det;

`ifdef STEPPER_PHASE_MON_SYNC_EN
  logic [3:0] sync_1;
  logic [3:0] sync_2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= '0;
      sync_2 <= '0;
      s_q    <= '0;
    end else begin
      sync_1 <= signal;
      sync_2 <= sync_1;
      s_q    <= sync_2;
    end
  end
`else
  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_q <= '0;
    else     s_q <= signal;
  end
`endif

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    code_idle  = 1'b0;
    code_legal = 1'b0;
    new_phase  = 2'd0;
    case (s_q)
      4'b0000: code_idle = 1'b1;
      4'b0001: begin code_legal = 1'b1; new_phase = 2'd0; end
      4'b0010: begin code_legal = 1'b1; new_phase = 2'd1; end
      4'b0100: begin code_legal = 1'b1; new_phase = 2'd2; end
      4'b1000: begin code_legal = 1'b1; new_phase = 2'd3; end
      default: ;
    endcase
    // 2-bit subtraction gives the phase distance modulo 4 for free.
    delta    = new_phase - last_phase;
    step_fwd = have_phase && code_legal && (delta == 2'd1);
    step_rev = have_phase && code_legal && (delta == 2'd3);
    err_det  = (!code_legal && !code_idle) ||
               (have_phase && code_legal && (delta == 2'd2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_phase <= 1'b0;
      last_phase <= 2'd0;
    end else if (code_legal) begin
      have_phase <= 1'b1;
      last_phase <= new_phase;
    end else if (!code_idle) begin
      have_phase <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_pulse <= 1'b0;
      step_dir   <= 1'b0;
      position   <= '0;
      revs       <= '0;
      err        <= 1'b0;
    end else begin
      step_pulse <= step_fwd || step_rev;
      if (step_fwd || step_rev) step_dir <= step_fwd;

      // A same-cycle clear overrides the step for position/revs only.
      if (clr) begin
        position <= '0;
        revs     <= '0;
      end else if (step_fwd) begin
        if (position == POS_MAX) begin
          position <= '0;
          revs     <= revs + REV_W'(1);
        end else begin
          position <= position + POS_W'(1);
        end
      end else if (step_rev) begin
        if (position == '0) begin
          position <= POS_MAX;
          revs     <= revs - REV_W'(1);
        end else begin
          position <= position - POS_W'(1);
        end
      end

      if (err_det)  err <= 1'b1;
      else if (clr) err <= 1'b0;
    end
  end

  // idle_cnt holds the number of step-free cycles left before moving drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      moving   <= 1'b0;
      idle_cnt <= '0;
    end else if (step_fwd || step_rev) begin
      moving   <= 1'b1;
      idle_cnt <= IDLE_LOAD;
    end else if (moving) begin
      if (idle_cnt == CNT_W'(1)) begin
        moving   <= 1'b0;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt - CNT_W'(1);
      end
    end
  end

endmodule
